// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: decode, forwarding, control and ALU-side signals of the EX operand stage
interface ex_operand_stage_if;
    logic        id_valid;
    logic [4:0]  id_alu_op;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic        id_use_imm;
    logic        id_use_shamt;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        exmem_reg_write;
    logic        exmem_mem_read;
    logic [4:0]  exmem_rd_addr;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd_addr;
    logic [31:0] memwb_result;
    logic        flush;
    logic        hold;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        ex_valid;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_store_data;
    logic        id_stall;

    modport master (
        output id_valid, id_alu_op, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_use_imm, id_use_shamt, id_rd_addr,
               id_reg_write, id_mem_read, id_mem_write,
               exmem_reg_write, exmem_mem_read, exmem_rd_addr, exmem_result,
               memwb_reg_write, memwb_rd_addr, memwb_result, flush, hold,
        input  alu_op, alu_a, alu_b, ex_valid, ex_rd_addr, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_store_data, id_stall
    );

    modport slave (
        input  id_valid, id_alu_op, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_use_imm, id_use_shamt, id_rd_addr,
               id_reg_write, id_mem_read, id_mem_write,
               exmem_reg_write, exmem_mem_read, exmem_rd_addr, exmem_result,
               memwb_reg_write, memwb_rd_addr, memwb_result, flush, hold,
        output alu_op, alu_a, alu_b, ex_valid, ex_rd_addr, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_store_data, id_stall
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with capture bypass, EX forwarding, operand select and load-use stall
module ex_operand_stage (
    input logic clk,
    input logic rst_n,
    ex_operand_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [4:0]  rsAddr;
        logic [4:0]  rtAddr;
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        useImm;
        logic        useShamt;
        logic [4:0]  rd;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } exState_t;

    exState_t cur, nxt, capture;
    logic memwbCapRs, memwbCapRt, exmemRs, exmemRt, memwbRs, memwbRt, loadUse;
    logic [31:0] fwdRs, fwdRt;

    assign memwbCapRs = bus.memwb_reg_write && bus.memwb_rd_addr != 5'd0 && bus.memwb_rd_addr == bus.id_rs_addr;
    assign memwbCapRt = bus.memwb_reg_write && bus.memwb_rd_addr != 5'd0 && bus.memwb_rd_addr == bus.id_rt_addr;
    assign exmemRs = bus.exmem_reg_write && bus.exmem_rd_addr != 5'd0 && bus.exmem_rd_addr == cur.rsAddr;
    assign exmemRt = bus.exmem_reg_write && bus.exmem_rd_addr != 5'd0 && bus.exmem_rd_addr == cur.rtAddr;
    assign memwbRs = bus.memwb_reg_write && bus.memwb_rd_addr != 5'd0 && bus.memwb_rd_addr == cur.rsAddr;
    assign memwbRt = bus.memwb_reg_write && bus.memwb_rd_addr != 5'd0 && bus.memwb_rd_addr == cur.rtAddr;
    assign fwdRs = exmemRs ? bus.exmem_result : memwbRs ? bus.memwb_result : cur.rsData;
    assign fwdRt = exmemRt ? bus.exmem_result : memwbRt ? bus.memwb_result : cur.rtData;
    assign loadUse = cur.valid && cur.memRead && cur.rd != 5'd0 && bus.id_valid &&
                     (cur.rd == bus.id_rs_addr || cur.rd == bus.id_rt_addr);

    assign bus.id_stall      = loadUse && !bus.flush;
    assign bus.alu_op        = cur.op;
    assign bus.alu_a         = cur.useShamt ? {27'b0, cur.shamt} : fwdRs;
    assign bus.alu_b         = cur.useImm ? cur.imm : fwdRt;
    assign bus.ex_store_data = fwdRt;
    assign bus.ex_valid      = cur.valid;
    assign bus.ex_rd_addr    = cur.rd;
    assign bus.ex_reg_write  = cur.regWrite;
    assign bus.ex_mem_read   = cur.memRead;
    assign bus.ex_mem_write  = cur.memWrite;

    // decode slot as it would be latched, with write-back data bypassing the register file
    always_comb begin
        capture.valid    = bus.id_valid;
        capture.op       = bus.id_alu_op;
        capture.rsAddr   = bus.id_rs_addr;
        capture.rtAddr   = bus.id_rt_addr;
        capture.rsData   = memwbCapRs ? bus.memwb_result : bus.id_rs_data;
        capture.rtData   = memwbCapRt ? bus.memwb_result : bus.id_rt_data;
        capture.imm      = bus.id_imm;
        capture.shamt    = bus.id_shamt;
        capture.useImm   = bus.id_use_imm;
        capture.useShamt = bus.id_use_shamt;
        capture.rd       = bus.id_rd_addr;
        capture.regWrite = bus.id_reg_write;
        capture.memRead  = bus.id_mem_read;
        capture.memWrite = bus.id_mem_write;
    end

    // hold freezes everything; flush or a load-use stall inserts a bubble
    always_comb begin
        nxt = bus.hold ? cur : (bus.flush || loadUse) ? '0 : capture;
    end

    // pipeline register, bubble on reset
    always_ff @(posedge clk) begin
        if (!rst_n) cur <= '0;
        else cur <= nxt;
    end
endmodule
